// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector: FSM state encoding
// and default sizing.
package seq_det_pkg;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2
  } state_e;

  localparam int DEF_PAT_W = 4;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/seq_shift_window.sv
// Serial shift window with a saturating fill counter. Also exposes the
// post-shift window/fill so the controller can compare in the same cycle.
module seq_shift_window #(
  parameter int PAT_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_i,
  input  logic                         shift_i,
  input  logic                         bit_i,
  output logic [PAT_W-1:0]             win_nxt_o,
  output logic [$clog2(PAT_W+1)-1:0]   fill_nxt_o
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  win_q;
  logic [FILL_W-1:0] fill_q;

  // Post-shift view: new bit enters at the LSB, fill saturates at PAT_W.
  always_comb begin
    win_nxt_o  = {win_q[PAT_W-2:0], bit_i};
    fill_nxt_o = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
  end

  // Window/fill register; a clear overrides a shift in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      win_q  <= '0;
      fill_q <= '0;
    end else if (shift_i) begin
      win_q  <= win_nxt_o;
      fill_q <= fill_nxt_o;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Configurable serial sequence detector: FSM, pattern compare, saturating
// match counter and registered detect pulse around a shift-window core.
module seq_detect_ctrl
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             cnt_clr,
  output logic             ready,
  output logic             detect,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_e            state_q, state_d;
  logic [PAT_W-1:0]  pattern_q;
  logic              overlap_q;
  logic              detect_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [PAT_W-1:0]  win_nxt;
  logic [FILL_W-1:0] fill_nxt;
  logic              accept;
  logic              match;
  logic              win_clr;

  // A bit is consumed only once configured, and a simultaneous load drops it.
  assign accept  = bit_valid && (state_q != UNCFG) && !cfg_load;
  assign match   = accept && (fill_nxt == FILL_FULL) && (win_nxt == pattern_q);
  // Reloading restarts the window; non-overlap mode restarts it after a hit.
  assign win_clr = cfg_load || (match && !overlap_q);

  seq_shift_window #(
    .PAT_W (PAT_W)
  ) u_window (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (win_clr),
    .shift_i    (accept),
    .bit_i      (bit_in),
    .win_nxt_o  (win_nxt),
    .fill_nxt_o (fill_nxt)
  );

  // Next-state and counter logic; clear beats increment, counter saturates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (cfg_load) begin
      state_d = FILL;
    end else if (accept) begin
      if (match && !overlap_q)     state_d = FILL;
      else if (fill_nxt == FILL_FULL) state_d = RUN;
      else                         state_d = FILL;
    end
    if (cnt_clr)                         cnt_d = '0;
    else if (match && cnt_q != CNT_MAX)  cnt_d = cnt_q + 1'b1;
  end

  // State, configuration, detect pulse and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= UNCFG;
      pattern_q <= '0;
      overlap_q <= 1'b0;
      detect_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q  <= state_d;
      detect_q <= match;
      cnt_q    <= cnt_d;
      if (cfg_load) begin
        pattern_q <= cfg_pattern;
        overlap_q <= cfg_overlap;
      end
    end
  end

  assign ready     = (state_q != UNCFG);
  assign detect    = detect_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl (PAT_W=4, CNT_W=2): directed vector table,
// a hand-written reset corner case, then random traffic vs a queue model.
module tb_seq_detect_ctrl;

  localparam int PAT_W = 4;
  localparam int CNT_W = 2;
  localparam int CMAX  = 3;

  logic             clk;
  logic             rst, cfg_load, cfg_overlap, bit_valid, bit_in, cnt_clr;
  logic [PAT_W-1:0] cfg_pattern;
  logic             ready, detect;
  logic [CNT_W-1:0] match_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_overlap (cfg_overlap),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .cnt_clr     (cnt_clr),
    .ready       (ready),
    .detect      (detect),
    .match_cnt   (match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             rst, load;
    logic [PAT_W-1:0] pat;
    logic             ov, bv, b, clr;
    int               rdy, det, cnt, fill;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, l, input logic [PAT_W-1:0] p,
                     input logic o, v, bi, c, input int er, ed, ec, ef);
    vec_t t;
    t.rst = r; t.load = l; t.pat = p; t.ov = o; t.bv = v; t.b = bi; t.clr = c;
    t.rdy = er; t.det = ed; t.cnt = ec; t.fill = ef;
    vecs.push_back(t);
  endtask

  task automatic step(input logic r, l, input logic [PAT_W-1:0] p,
                      input logic o, v, bi, c);
    rst = r; cfg_load = l; cfg_pattern = p; cfg_overlap = o;
    bit_valid = v; bit_in = bi; cnt_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int er, ed, ec, ef);
    check({tag, ".ready"},  int'(ready),               er);
    check({tag, ".detect"}, int'(detect),              ed);
    check({tag, ".cnt"},    int'(match_cnt),           ec);
    check({tag, ".fill"},   int'(dut.u_window.fill_q), ef);
  endtask

  // Reference model: history of accepted bits since the last window restart.
  bit          m_cfg;
  bit [3:0]    m_pat;
  bit          m_ov;
  int          m_cnt;
  int          m_det;
  int          m_hist[$];

  task automatic model_step(input bit r, l, input bit [3:0] p,
                            input bit o, v, bi, c);
    int val;
    int hit;
    hit = 0;
    if (r) begin
      m_cfg = 0; m_pat = '0; m_ov = 0; m_cnt = 0; m_det = 0;
      m_hist.delete();
      return;
    end
    if (l) begin
      m_cfg = 1; m_pat = p; m_ov = o;
      m_hist.delete();
    end else if (m_cfg && v) begin
      m_hist.push_back(int'(bi));
      if (m_hist.size() > PAT_W) void'(m_hist.pop_front());
      if (m_hist.size() == PAT_W) begin
        val = 0;
        foreach (m_hist[k]) val = val * 2 + m_hist[k];
        if (val == int'(m_pat)) begin
          hit = 1;
          if (!m_ov) m_hist.delete();
        end
      end
    end
    m_det = hit;
    if (c)                        m_cnt = 0;
    else if (hit && m_cnt < CMAX) m_cnt = m_cnt + 1;
  endtask

  initial begin
    logic [PAT_W-1:0] pats[5];
    logic r, l, o, v, bi, c;
    logic [PAT_W-1:0] p;

    rst = 1'b0; cfg_load = 1'b0; cfg_pattern = '0; cfg_overlap = 1'b0;
    bit_valid = 1'b0; bit_in = 1'b0; cnt_clr = 1'b0;

    // ---- directed table: rst, load, pat, ov, bv, b, clr | ready, det, cnt, fill
    add(1,0,4'b0000,0,0,0,0, 0,0,0,0);
    // bits before configuration are ignored (pattern is 0000 after reset)
    add(0,0,4'b0000,0,1,0,0, 0,0,0,0);
    add(0,0,4'b0000,0,1,0,0, 0,0,0,0);
    add(0,0,4'b0000,0,1,0,0, 0,0,0,0);
    add(0,0,4'b0000,0,1,0,0, 0,0,0,0);
    // overlap mode, 1011, stream 1,0,1,1,0,1,1
    add(0,1,4'b1011,1,0,0,0, 1,0,0,0);
    add(0,0,4'b0000,0,1,1,0, 1,0,0,1);
    add(0,0,4'b0000,0,1,0,0, 1,0,0,2);
    add(0,0,4'b0000,0,1,1,0, 1,0,0,3);
    add(0,0,4'b0000,0,1,1,0, 1,1,1,4);
    add(0,0,4'b0000,0,1,0,0, 1,0,1,4);
    add(0,0,4'b0000,0,1,1,0, 1,0,1,4);
    add(0,0,4'b0000,0,1,1,0, 1,1,2,4);
    // non-overlap mode, same stream; count keeps across reload
    add(0,1,4'b1011,0,0,0,0, 1,0,2,0);
    add(0,0,4'b0000,0,1,1,0, 1,0,2,1);
    add(0,0,4'b0000,0,1,0,0, 1,0,2,2);
    add(0,0,4'b0000,0,1,1,0, 1,0,2,3);
    add(0,0,4'b0000,0,1,1,0, 1,1,3,0);
    add(0,0,4'b0000,0,1,0,0, 1,0,3,1);
    add(0,0,4'b0000,0,1,1,0, 1,0,3,2);
    add(0,0,4'b0000,0,1,1,0, 1,0,3,3);
    // standalone clear
    add(0,0,4'b0000,0,0,0,1, 1,0,0,3);
    // saturation: 1111 overlap, eight 1s
    add(0,1,4'b1111,1,0,0,0, 1,0,0,0);
    add(0,0,4'b0000,0,1,1,0, 1,0,0,1);
    add(0,0,4'b0000,0,1,1,0, 1,0,0,2);
    add(0,0,4'b0000,0,1,1,0, 1,0,0,3);
    add(0,0,4'b0000,0,1,1,0, 1,1,1,4);
    add(0,0,4'b0000,0,1,1,0, 1,1,2,4);
    add(0,0,4'b0000,0,1,1,0, 1,1,3,4);
    add(0,0,4'b0000,0,1,1,0, 1,1,3,4);
    add(0,0,4'b0000,0,1,1,0, 1,1,3,4);
    // clear coincident with a match: detect pulses, clear wins
    add(0,0,4'b0000,0,1,1,1, 1,1,0,4);
    add(0,0,4'b0000,0,1,0,0, 1,0,0,4);
    // reload together with a completing bit: bit dropped
    add(0,1,4'b1011,1,0,0,0, 1,0,0,0);
    add(0,0,4'b0000,0,1,1,0, 1,0,0,1);
    add(0,0,4'b0000,0,1,0,0, 1,0,0,2);
    add(0,0,4'b0000,0,1,1,0, 1,0,0,3);
    add(0,1,4'b1011,1,1,1,0, 1,0,0,0);
    add(0,0,4'b0000,0,0,0,0, 1,0,0,0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].load, vecs[i].pat, vecs[i].ov,
           vecs[i].bv, vecs[i].b, vecs[i].clr);
      $display("vec %0d: rst=%0b load=%0b bv=%0b b=%0b clr=%0b -> ready=%0b detect=%0b cnt=%0d fill=%0d",
               i, vecs[i].rst, vecs[i].load, vecs[i].bv, vecs[i].b, vecs[i].clr,
               ready, detect, match_cnt, dut.u_window.fill_q);
      check_all($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].det, vecs[i].cnt, vecs[i].fill);
    end

    // ---- hand-written: reset mid-sequence discards the partial match
    step(0,1,4'b1011,1,0,0,0);
    step(0,0,4'b0000,0,1,1,0);
    step(0,0,4'b0000,0,1,1,0);           // fill cnt to 1 from 0 via match? no: stream 1,1
    step(0,1,4'b1011,1,0,0,0);
    step(0,0,4'b0000,0,1,1,0);
    step(0,0,4'b0000,0,1,0,0);
    step(0,0,4'b0000,0,1,1,0);
    step(1,1,4'b1011,1,1,1,1);
    $display("seq rst: ready=%0b detect=%0b cnt=%0d fill=%0d", ready, detect, match_cnt, dut.u_window.fill_q);
    check_all("rst_mid", 0, 0, 0, 0);
    step(0,1,4'b1011,0,0,0,0);
    step(0,0,4'b0000,0,1,1,0);
    $display("seq reload: ready=%0b detect=%0b cnt=%0d fill=%0d", ready, detect, match_cnt, dut.u_window.fill_q);
    check_all("after_rst", 1, 0, 0, 1);
    // back-to-back bits complete 1011 with no bubble
    step(0,0,4'b0000,0,1,0,0);
    step(0,0,4'b0000,0,1,1,0);
    step(0,0,4'b0000,0,1,1,0);
    $display("seq b2b: ready=%0b detect=%0b cnt=%0d fill=%0d", ready, detect, match_cnt, dut.u_window.fill_q);
    check_all("b2b", 1, 1, 1, 0);

    // ---- random traffic against the model
    pats[0] = 4'b1011; pats[1] = 4'b1111; pats[2] = 4'b0000;
    pats[3] = 4'b1010; pats[4] = 4'($urandom_range(0, 15));
    step(1,0,4'b0000,0,0,0,0);
    model_step(1,0,4'b0000,0,0,0,0);
    for (int t = 0; t < 600; t++) begin
      r  = ($urandom_range(0, 99) == 0);
      l  = ($urandom_range(0, 39) == 0);
      p  = pats[$urandom_range(0, 4)];
      o  = 1'($urandom_range(0, 1));
      v  = ($urandom_range(0, 3) != 0);
      bi = 1'($urandom_range(0, 1));
      c  = ($urandom_range(0, 29) == 0);
      step(r, l, p, o, v, bi, c);
      model_step(r, l, p, o, v, bi, c);
      $display("rnd %0d: rst=%0b load=%0b pat=%b ov=%0b bv=%0b b=%0b clr=%0b -> ready=%0b detect=%0b cnt=%0d",
               t, r, l, p, o, v, bi, c, ready, detect, match_cnt);
      check_all($sformatf("rnd%0d", t), int'(m_cfg), m_det, m_cnt,
                (m_hist.size() > PAT_W) ? PAT_W : m_hist.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
